axi_wdata_sched: RTL and testbench

//  Write-data channel scheduler for the AXI interconnect. Records the order of AW grants

---
 rtl/axi_wdata_sched_if.sv | 62 ++++++
 rtl/axi_wdata_sched.sv | 141 ++++++++++++++
 tb/tb_axi_wdata_sched.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wdata_sched_if.sv
// rtl/axi_wdata_sched_if.sv - AW grant and W channel signals of the write-data scheduler
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

interface axi_wdata_sched_if #(
  parameter int NUM_S = 3,
  parameter int SLV_W = 2
);
  logic                      aw_push;
  logic                      aw_mst;
  logic [SLV_W-1:0]          aw_slv;
  logic [`AXI_LEN_BITS-1:0]  aw_len;
  logic                      aw_ready;

  logic [`AXI_DATA_BITS-1:0] WDATA_M0;
  logic [`AXI_STRB_BITS-1:0] WSTRB_M0;
  logic                      WLAST_M0;
  logic                      WVALID_M0;
  logic                      WREADY_M0;
  logic [`AXI_DATA_BITS-1:0] WDATA_M1;
  logic [`AXI_STRB_BITS-1:0] WSTRB_M1;
  logic                      WLAST_M1;
  logic                      WVALID_M1;
  logic                      WREADY_M1;

  logic [`AXI_DATA_BITS-1:0] WDATA_S;
  logic [`AXI_STRB_BITS-1:0] WSTRB_S;
  logic                      WLAST_S;
  logic [NUM_S-1:0]          WVALID_S;
  logic [NUM_S-1:0]          WREADY_S;

  logic                      busy;
  logic                      len_err;

  // slave: the scheduler side; master: arbiter, W masters and W slaves around it
  modport slave (
    input  aw_push, aw_mst, aw_slv, aw_len,
    input  WDATA_M0, WSTRB_M0, WLAST_M0, WVALID_M0,
    input  WDATA_M1, WSTRB_M1, WLAST_M1, WVALID_M1,
    input  WREADY_S,
    output aw_ready, WREADY_M0, WREADY_M1,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    output busy, len_err
  );

  modport master (
    output aw_push, aw_mst, aw_slv, aw_len,
    output WDATA_M0, WSTRB_M0, WLAST_M0, WVALID_M0,
    output WDATA_M1, WSTRB_M1, WLAST_M1, WVALID_M1,
    output WREADY_S,
    input  aw_ready, WREADY_M0, WREADY_M1,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    input  busy, len_err
  );
endinterface

// File: rtl/axi_wdata_sched.sv
// rtl/axi_wdata_sched.sv - in-order W channel scheduler driven by the AW grant queue
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_wdata_sched #(
  parameter int DEPTH = 4,
  parameter int NUM_S = 3,
  parameter int SLV_W = 2
) (
  input  logic                clk,
  input  logic                rstn,
  axi_wdata_sched_if.slave    bus
);
  localparam int LEN_W = `AXI_LEN_BITS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  typedef enum logic {IDLE, ROUTE} state_t;

  state_t           state;
  logic             q_mst [DEPTH];
  logic [SLV_W-1:0] q_slv [DEPTH];
  logic [LEN_W-1:0] q_len [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             cur_mst;
  logic [SLV_W-1:0] cur_slv;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] cnt;
  logic             len_err_q;

  logic full, empty, push, pop;
  logic route, last, beat;
  logic sel_valid, sel_wlast, sel_ready;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.aw_push & ~full;
  assign pop   = (state == IDLE) & ~empty;
  assign route = (state == ROUTE);
  assign last  = (cnt == cur_len);

  always_comb begin
    sel_valid = cur_mst ? bus.WVALID_M1 : bus.WVALID_M0;
    sel_wlast = cur_mst ? bus.WLAST_M1  : bus.WLAST_M0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_S; i++) begin
      if (cur_slv == SLV_W'(i)) sel_ready = bus.WREADY_S[i];
    end
    beat = route & sel_valid & sel_ready;
  end

  // Outputs follow the selected master combinationally so stalls cost no extra cycle
  always_comb begin
    bus.WDATA_S   = '0;
    bus.WSTRB_S   = '0;
    bus.WLAST_S   = 1'b0;
    bus.WVALID_S  = '0;
    bus.WREADY_M0 = 1'b0;
    bus.WREADY_M1 = 1'b0;
    if (route) begin
      bus.WDATA_S   = cur_mst ? bus.WDATA_M1 : bus.WDATA_M0;
      bus.WSTRB_S   = cur_mst ? bus.WSTRB_M1 : bus.WSTRB_M0;
      bus.WLAST_S   = last;
      for (int i = 0; i < NUM_S; i++) begin
        if (cur_slv == SLV_W'(i)) bus.WVALID_S[i] = sel_valid;
      end
      bus.WREADY_M0 = ~cur_mst & sel_ready;
      bus.WREADY_M1 = cur_mst & sel_ready;
    end
  end

  assign bus.aw_ready = ~full;
  assign bus.busy     = route | ~empty;
  assign bus.len_err  = len_err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      q_mst[wr_ptr] <= bus.aw_mst;
      q_slv[wr_ptr] <= bus.aw_slv;
      q_len[wr_ptr] <= bus.aw_len;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The burst always ends on the counted last beat; the master's WLAST only feeds len_err
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cur_mst   <= 1'b0;
      cur_slv   <= '0;
      cur_len   <= '0;
      cnt       <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= beat & (sel_wlast != last);
      case (state)
        IDLE: begin
          if (!empty) begin
            cur_mst <= q_mst[rd_ptr];
            cur_slv <= q_slv[rd_ptr];
            cur_len <= q_len[rd_ptr];
            cnt     <= '0;
            state   <= ROUTE;
          end
        end
        ROUTE: begin
          if (beat) begin
            if (last) state <= IDLE;
            else      cnt   <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_wdata_sched.sv
// tb/tb_axi_wdata_sched.sv - directed vector bench for axi_wdata_sched
`timescale 1ns/1ps
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_axi_wdata_sched;
  localparam int NUM_S = 3;
  localparam int SLV_W = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  axi_wdata_sched_if #(.NUM_S(NUM_S), .SLV_W(SLV_W)) bus();

  axi_wdata_sched #(.DEPTH(DEPTH), .NUM_S(NUM_S), .SLV_W(SLV_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int beats_seen = 0;
  int full_push_seen = 0;

  // Beats and ignored pushes are counted on the falling edge, where everything is settled
  always @(negedge clk) begin
    if (rstn) begin
      if (|(bus.WVALID_S & bus.WREADY_S)) beats_seen++;
      if (bus.aw_push && !bus.aw_ready) full_push_seen++;
    end
  end

  typedef struct {
    logic       vm0;
    logic       vm1;
    logic       lm0;
    logic [2:0] rs;
    logic [2:0] e_vs;
    logic       e_rm0;
    logic       e_rm1;
    logic       e_wlast;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.aw_push = 1'b0; bus.aw_mst = 1'b0; bus.aw_slv = '0; bus.aw_len = '0;
    bus.WDATA_M0 = '0; bus.WSTRB_M0 = '0; bus.WLAST_M0 = 1'b0; bus.WVALID_M0 = 1'b0;
    bus.WDATA_M1 = '0; bus.WSTRB_M1 = '0; bus.WLAST_M1 = 1'b0; bus.WVALID_M1 = 1'b0;
    bus.WREADY_S = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic push(input logic m, input logic [SLV_W-1:0] s, input logic [7:0] l);
    bus.aw_mst = m; bus.aw_slv = s; bus.aw_len = l; bus.aw_push = 1'b1;
    tick();
    bus.aw_push = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, bus.busy, 1'b0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " WVALID_S"}, bus.WVALID_S, 3'b000);
    chk({tag, " WREADY_M0"}, bus.WREADY_M0, 1'b0);
    chk({tag, " WREADY_M1"}, bus.WREADY_M1, 1'b0);
    chk({tag, " WDATA_S"}, bus.WDATA_S, 32'h0);
    chk({tag, " WLAST_S"}, bus.WLAST_S, 1'b0);
    chk({tag, " len_err"}, bus.len_err, 1'b0);
    chk({tag, " busy"}, bus.busy, 1'b0);
    chk({tag, " aw_ready"}, bus.aw_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0;
    //           vm0   vm1   lm0   rs      e_vs    rm0   rm1   wlast
    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 3'b101, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 3'b111, 3'b010, 1'b1, 1'b0, 1'b0};

    clear_inputs();
    tick();
    chk_quiet("reset");
    rstn = 1'b1;
    tick();
    chk_quiet("post-reset");

    // Single burst {M0,S1,len=3}; first vectors exercise routing combinationally at cnt 0
    push(1'b0, 2'd1, 8'd3);
    bus.WVALID_M0 = 1'b1; bus.WREADY_S = 3'b010;
    chk("t1 popping busy", bus.busy, 1'b1);
    chk("t1 idle WVALID_S", bus.WVALID_S, 3'b000);
    bus.WVALID_M0 = 1'b0;
    tick();
    bus.WSTRB_M0 = 4'h3; bus.WSTRB_M1 = 4'hC;
    for (int i = 0; i < 6; i++) begin
      bus.WVALID_M0 = vecs[i].vm0; bus.WVALID_M1 = vecs[i].vm1;
      bus.WLAST_M0 = vecs[i].lm0; bus.WREADY_S = vecs[i].rs;
      bus.WDATA_M0 = 32'hA0A0_0000 + i; bus.WDATA_M1 = 32'hB1B1_0000 + i;
      #1;
      chk($sformatf("vec%0d WVALID_S", i), bus.WVALID_S, vecs[i].e_vs);
      chk($sformatf("vec%0d WREADY_M0", i), bus.WREADY_M0, vecs[i].e_rm0);
      chk($sformatf("vec%0d WREADY_M1", i), bus.WREADY_M1, vecs[i].e_rm1);
      chk($sformatf("vec%0d WLAST_S", i), bus.WLAST_S, vecs[i].e_wlast);
      chk($sformatf("vec%0d WDATA_S", i), bus.WDATA_S, 32'hA0A0_0000 + i);
      chk($sformatf("vec%0d WSTRB_S", i), bus.WSTRB_S, 4'h3);
    end
    bus.WVALID_M0 = 1'b0; bus.WVALID_M1 = 1'b0; bus.WLAST_M0 = 1'b0;
    tick();
    bus.WVALID_M0 = 1'b1; bus.WREADY_S = 3'b010;
    for (int b = 0; b < 4; b++) begin
      bus.WDATA_M0 = 32'h1000 + b; bus.WLAST_M0 = (b == 3);
      #1;
      chk($sformatf("t1 beat%0d WVALID_S", b), bus.WVALID_S, 3'b010);
      chk($sformatf("t1 beat%0d WLAST_S", b), bus.WLAST_S, (b == 3));
      chk($sformatf("t1 beat%0d WDATA_S", b), bus.WDATA_S, 32'h1000 + b);
      chk($sformatf("t1 beat%0d len_err", b), bus.len_err, 1'b0);
      tick();
    end
    chk("t1 done busy", bus.busy, 1'b0);
    chk("t1 done WVALID_S", bus.WVALID_S, 3'b000);
    chk("t1 done len_err", bus.len_err, 1'b0);
    clear_inputs();

    // Ordering: {M1,S0,0} then {M0,S2,1}, both masters valid throughout
    bus.WREADY_S = 3'b111; bus.WVALID_M0 = 1'b1; bus.WVALID_M1 = 1'b1;
    bus.WLAST_M1 = 1'b1; bus.WDATA_M0 = 32'hC0; bus.WDATA_M1 = 32'hC1;
    push(1'b1, 2'd0, 8'd0);
    push(1'b0, 2'd2, 8'd1);
    chk("t2 m1 WVALID_S", bus.WVALID_S, 3'b001);
    chk("t2 m1 WLAST_S", bus.WLAST_S, 1'b1);
    chk("t2 m1 WREADY_M1", bus.WREADY_M1, 1'b1);
    chk("t2 m1 WREADY_M0", bus.WREADY_M0, 1'b0);
    chk("t2 m1 WDATA_S", bus.WDATA_S, 32'hC1);
    tick();
    chk("t2 bubble WVALID_S", bus.WVALID_S, 3'b000);
    chk("t2 bubble busy", bus.busy, 1'b1);
    tick();
    chk("t2 m0a WVALID_S", bus.WVALID_S, 3'b100);
    chk("t2 m0a WREADY_M0", bus.WREADY_M0, 1'b1);
    chk("t2 m0a WREADY_M1", bus.WREADY_M1, 1'b0);
    chk("t2 m0a WLAST_S", bus.WLAST_S, 1'b0);
    bus.WLAST_M0 = 1'b1;
    tick();
    chk("t2 m0b WVALID_S", bus.WVALID_S, 3'b100);
    chk("t2 m0b WLAST_S", bus.WLAST_S, 1'b1);
    tick();
    chk("t2 done busy", bus.busy, 1'b0);
    chk("t2 done len_err", bus.len_err, 1'b0);

    // Full: one burst held in ROUTE plus four queued grants fill the queue
    do_reset();
    for (int i = 0; i < 4; i++) push(1'b0, 2'd0, 8'd0);
    chk("t3 aw_ready before full", bus.aw_ready, 1'b1);
    push(1'b0, 2'd0, 8'd0);
    chk("t3 aw_ready full", bus.aw_ready, 1'b0);
    bus.aw_mst = 1'b1; bus.aw_slv = 2'd2; bus.aw_len = 8'd0; bus.aw_push = 1'b1;
    tick();
    bus.aw_push = 1'b0;
    chk("t3 push while full seen", full_push_seen, 1);
    chk("t3 aw_ready still full", bus.aw_ready, 1'b0);
    b0 = beats_seen;
    bus.WVALID_M0 = 1'b1; bus.WLAST_M0 = 1'b1; bus.WREADY_S = 3'b001;
    tick();
    chk("t3 aw_ready before pop", bus.aw_ready, 1'b0);
    tick();
    chk("t3 aw_ready after pop", bus.aw_ready, 1'b1);
    wait_idle("t3 drain", 40);
    chk("t3 beats", beats_seen - b0, 5);

    // Early WLAST on beat 2 of len=2 burst
    do_reset();
    push(1'b0, 2'd0, 8'd2);
    bus.WVALID_M0 = 1'b1; bus.WREADY_S = 3'b001;
    tick();
    chk("t4 beat1 WLAST_S", bus.WLAST_S, 1'b0);
    tick();
    chk("t4 beat2 len_err", bus.len_err, 1'b0);
    bus.WLAST_M0 = 1'b1;
    tick();
    chk("t4 beat3 len_err", bus.len_err, 1'b1);
    chk("t4 beat3 WLAST_S", bus.WLAST_S, 1'b1);
    chk("t4 beat3 WVALID_S", bus.WVALID_S, 3'b001);
    tick();
    chk("t4 done len_err", bus.len_err, 1'b0);
    chk("t4 done busy", bus.busy, 1'b0);

    // Late WLAST: burst still ends on the counted last beat
    bus.WLAST_M0 = 1'b0;
    push(1'b0, 2'd0, 8'd1);
    tick();
    tick();
    chk("t4 late WLAST_S", bus.WLAST_S, 1'b1);
    tick();
    chk("t4 late len_err", bus.len_err, 1'b1);
    chk("t4 late busy", bus.busy, 1'b0);

    // Backpressure: WREADY_S[1] = 1,0,0,1 across a len=1 burst
    do_reset();
    push(1'b0, 2'd1, 8'd1);
    b0 = beats_seen;
    bus.WVALID_M0 = 1'b1; bus.WDATA_M0 = 32'hD0; bus.WREADY_S = 3'b010;
    tick();
    chk("t5 b1 WDATA_S", bus.WDATA_S, 32'hD0);
    chk("t5 b1 WLAST_S", bus.WLAST_S, 1'b0);
    tick();
    bus.WDATA_M0 = 32'hD1; bus.WREADY_S = 3'b000;
    #1;
    chk("t5 stall1 WREADY_M0", bus.WREADY_M0, 1'b0);
    chk("t5 stall1 WVALID_S", bus.WVALID_S, 3'b010);
    chk("t5 stall1 WLAST_S", bus.WLAST_S, 1'b1);
    tick();
    chk("t5 stall2 WDATA_S", bus.WDATA_S, 32'hD1);
    chk("t5 stall2 WLAST_S", bus.WLAST_S, 1'b1);
    chk("t5 stall2 busy", bus.busy, 1'b1);
    bus.WREADY_S = 3'b010;
    #1;
    chk("t5 b2 WREADY_M0", bus.WREADY_M0, 1'b1);
    tick();
    chk("t5 done busy", bus.busy, 1'b0);
    chk("t5 beats", beats_seen - b0, 2);

    // Reset after beat 1 of a len=3 burst
    do_reset();
    push(1'b0, 2'd1, 8'd3);
    bus.WVALID_M0 = 1'b1; bus.WREADY_S = 3'b010; bus.WDATA_M0 = 32'hE0;
    tick();
    tick();
    rstn = 1'b0;
    bus.WREADY_S = 3'b111;
    #1;
    chk_quiet("t6 in reset");
    tick();
    rstn = 1'b1;
    b0 = beats_seen;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t6 idle%0d WVALID_S", i), bus.WVALID_S, 3'b000);
    end
    chk("t6 no beats", beats_seen - b0, 0);
    bus.WVALID_M1 = 1'b1; bus.WLAST_M1 = 1'b1;
    push(1'b1, 2'd2, 8'd0);
    tick();
    chk("t6 new WVALID_S", bus.WVALID_S, 3'b100);
    chk("t6 new WREADY_M1", bus.WREADY_M1, 1'b1);
    tick();
    chk("t6 new done busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
